// File: rtl/adc_seq_pkg.sv
// Shared types and sizing for the ADC measurement sequencer.
// Optional build macro: ADC_SEQ_AVERAGING_EN (multi-sample averaging).
package adc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    READ,
    WAIT_CC_LOW,
    DONE
  } seq_state_e;

  localparam int unsigned SAMPLE_CNT_W     = 4;
  localparam int unsigned MAX_LOG2_SAMPLES = 3;

  // Accumulator holds up to 8 full-scale samples without overflow.
  function automatic int unsigned acc_width(input int unsigned adc_width);
    return adc_width + MAX_LOG2_SAMPLES;
  endfunction

endpackage

// File: rtl/adc_seq_timer.sv
// Loadable down-counter with zero flag, shared by settle and timeout phases.
module adc_seq_timer #(
  parameter int unsigned WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero_c
);

  logic [WIDTH-1:0] cnt_q;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/adc_measurement_sequencer.sv
// Command-driven sensor/ADC power-up, settle, conversion and result return.
// Optional build macro: ADC_SEQ_AVERAGING_EN (1..8 samples averaged);
// without it exactly one sample is taken and returned unshifted.
module adc_measurement_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned SETTLE_TICKS  = 136,
  parameter int unsigned TIMEOUT_TICKS = 13560,
  parameter int unsigned ADC_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 abort,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_sens_config,
  input  logic [1:0]           cmd_log2_samples,
  input  logic                 cmd_keep_powered,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ADC_WIDTH-1:0] rsp_value,
  output logic                 rsp_timeout,
  output logic [2:0]           sens_config,
  output logic                 sens_enable,
  output logic                 sens_read,
  output logic                 adc_enable,
  output logic                 adc_read,
  input  logic                 adc_conversion_complete,
  input  logic [ADC_WIDTH-1:0] adc_value
);

  localparam int unsigned MAX_TICKS = (SETTLE_TICKS > TIMEOUT_TICKS) ? SETTLE_TICKS : TIMEOUT_TICKS;
  localparam int unsigned TMR_W     = (MAX_TICKS > 2) ? $clog2(MAX_TICKS) : 1;

  seq_state_e              state_q, state_d;
  logic                    clear_c;
  logic                    enable_q, enable_d;
  logic                    read_q, read_d;
  logic                    powered_q, powered_d;
  logic                    keep_q, keep_d;
  logic [SAMPLE_CNT_W-1:0] sample_cnt_q, sample_cnt_d, samples_c;
  logic                    cmd_ready_d, rsp_valid_d, rsp_timeout_d;
  logic [ADC_WIDTH-1:0]    rsp_value_d, result_c;
  logic [2:0]              sens_config_d;
  logic                    tmr_load, tmr_dec, tmr_zero_c;
  logic [TMR_W-1:0]        tmr_load_value;

  assign clear_c = rst || abort;

`ifdef ADC_SEQ_AVERAGING_EN
  localparam int unsigned ACC_W = acc_width(ADC_WIDTH);
  logic [ACC_W-1:0] acc_q, acc_d, acc_add_c;
  logic [1:0]       log2_q;

  // Sample count for this command is latched at accept.
  always_ff @(posedge clk) begin
    if (clear_c) begin
      log2_q <= '0;
    end else if ((state_q == IDLE) && cmd_valid) begin
      log2_q <= cmd_log2_samples;
    end
  end

  assign samples_c = SAMPLE_CNT_W'(1) << cmd_log2_samples;
  assign acc_add_c = acc_q + ACC_W'(adc_value);
  assign result_c  = ADC_WIDTH'(acc_q >> log2_q);
`else
  logic [ADC_WIDTH-1:0] acc_q, acc_d, acc_add_c;
  logic                 unused_log2;

  assign unused_log2 = ^cmd_log2_samples;
  assign samples_c   = SAMPLE_CNT_W'(1);
  assign acc_add_c   = adc_value;
  assign result_c    = acc_q;
`endif

  adc_seq_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (clear_c),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .dec        (tmr_dec),
    .zero_c     (tmr_zero_c)
  );

  // State and registered outputs; reset and abort both return to idle.
  always_ff @(posedge clk) begin
    if (clear_c) begin
      state_q      <= IDLE;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_value    <= '0;
      rsp_timeout  <= 1'b0;
      sens_config  <= '0;
      enable_q     <= 1'b0;
      read_q       <= 1'b0;
      powered_q    <= 1'b0;
      keep_q       <= 1'b0;
      sample_cnt_q <= '0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready    <= cmd_ready_d;
      rsp_valid    <= rsp_valid_d;
      rsp_value    <= rsp_value_d;
      rsp_timeout  <= rsp_timeout_d;
      sens_config  <= sens_config_d;
      enable_q     <= enable_d;
      read_q       <= read_d;
      powered_q    <= powered_d;
      keep_q       <= keep_d;
      sample_cnt_q <= sample_cnt_d;
      acc_q        <= acc_d;
    end
  end

  // Next-state and next-output decode; everything holds unless changed.
  always_comb begin
    state_d        = state_q;
    cmd_ready_d    = cmd_ready;
    rsp_valid_d    = rsp_valid;
    rsp_value_d    = rsp_value;
    rsp_timeout_d  = rsp_timeout;
    sens_config_d  = sens_config;
    enable_d       = enable_q;
    read_d         = read_q;
    powered_d      = powered_q;
    keep_d         = keep_q;
    sample_cnt_d   = sample_cnt_q;
    acc_d          = acc_q;
    tmr_load       = 1'b0;
    tmr_load_value = '0;
    tmr_dec        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_ready_d   = 1'b0;
          sens_config_d = cmd_sens_config;
          keep_d        = cmd_keep_powered;
          enable_d      = 1'b1;
          powered_d     = 1'b1;
          sample_cnt_d  = samples_c;
          acc_d         = '0;
          rsp_value_d   = '0;
          rsp_timeout_d = 1'b0;
          tmr_load      = 1'b1;
          // Already powered with the same configuration: sensor is settled.
          if (powered_q && (cmd_sens_config == sens_config)) begin
            state_d        = READ;
            read_d         = 1'b1;
            tmr_load_value = TMR_W'(TIMEOUT_TICKS - 1);
          end else begin
            state_d        = SETTLE;
            tmr_load_value = TMR_W'(SETTLE_TICKS - 1);
          end
        end
      end
      SETTLE: begin
        if (tmr_zero_c) begin
          state_d        = READ;
          read_d         = 1'b1;
          tmr_load       = 1'b1;
          tmr_load_value = TMR_W'(TIMEOUT_TICKS - 1);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      READ: begin
        if (adc_conversion_complete) begin
          acc_d   = acc_add_c;
          read_d  = 1'b0;
          state_d = WAIT_CC_LOW;
        end else if (tmr_zero_c) begin
          // A timeout always powers the sensor down.
          read_d        = 1'b0;
          enable_d      = 1'b0;
          powered_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_value_d   = '0;
          rsp_timeout_d = 1'b1;
          state_d       = DONE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      WAIT_CC_LOW: begin
        if (!adc_conversion_complete) begin
          if (sample_cnt_q == SAMPLE_CNT_W'(1)) begin
            rsp_valid_d = 1'b1;
            rsp_value_d = result_c;
            if (!keep_q) begin
              enable_d  = 1'b0;
              powered_d = 1'b0;
            end
            state_d = DONE;
          end else begin
            sample_cnt_d   = sample_cnt_q - SAMPLE_CNT_W'(1);
            read_d         = 1'b1;
            tmr_load       = 1'b1;
            tmr_load_value = TMR_W'(TIMEOUT_TICKS - 1);
            state_d        = READ;
          end
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_value_d   = '0;
          rsp_timeout_d = 1'b0;
          cmd_ready_d   = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sens_enable = enable_q;
  assign adc_enable  = enable_q;
  assign sens_read   = read_q;
  assign adc_read    = read_q;

endmodule

// File: tb/tb_adc_measurement_sequencer.sv
// Scoreboard bench for adc_measurement_sequencer: directed commands push
// expected responses, a monitor pops and compares on each response handshake.
module tb_adc_measurement_sequencer;

  localparam int unsigned SETTLE  = 136;
  localparam int unsigned TIMEOUT = 13560;

  typedef struct {
    logic [15:0] value;
    logic        timeout;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst, abort, cmd_valid, cmd_ready, cmd_keep_powered;
  logic [2:0]  cmd_sens_config, sens_config;
  logic [1:0]  cmd_log2_samples;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [15:0] rsp_value, adc_value;
  logic        sens_enable, sens_read, adc_enable, adc_read, adc_conversion_complete;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned rsp_idx = 0;
  int unsigned read_rises = 0;
  logic        read_prev = 1'b0;
  rsp_t        exp_q[$];
  rsp_t        mon_exp;
  logic [15:0] adc_vals[$];
  int          adc_delay = 1;
  bit          adc_hang = 1'b0;

  always #5 clk = ~clk;

  adc_measurement_sequencer dut (
    .clk                     (clk),
    .rst                     (rst),
    .abort                   (abort),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_sens_config         (cmd_sens_config),
    .cmd_log2_samples        (cmd_log2_samples),
    .cmd_keep_powered        (cmd_keep_powered),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_value               (rsp_value),
    .rsp_timeout             (rsp_timeout),
    .sens_config             (sens_config),
    .sens_enable             (sens_enable),
    .sens_read               (sens_read),
    .adc_enable              (adc_enable),
    .adc_read                (adc_read),
    .adc_conversion_complete (adc_conversion_complete),
    .adc_value               (adc_value)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ADC model: after adc_delay cycles of a read, complete with the next value
  // and hold complete until the read is withdrawn.
  initial begin
    adc_conversion_complete = 1'b0;
    adc_value = '0;
    forever begin
      @(negedge clk);
      if (adc_read && !adc_hang) begin
        repeat (adc_delay - 1) @(negedge clk);
        adc_value = (adc_vals.size() > 0) ? adc_vals.pop_front() : 16'hDEAD;
        adc_conversion_complete = 1'b1;
        for (int i = 0; i < 100 && adc_read; i++) @(negedge clk);
        adc_conversion_complete = 1'b0;
      end
    end
  end

  // Read pulse counter.
  always @(negedge clk) begin
    if (sens_read && !read_prev) read_rises++;
    read_prev <= sens_read;
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got value 0x%0h timeout %0b, required no response", rsp_value, rsp_timeout);
      end else begin
        mon_exp = exp_q.pop_front();
        check($sformatf("rsp%0d_value", rsp_idx), 32'(rsp_value), 32'(mon_exp.value));
        check($sformatf("rsp%0d_timeout", rsp_idx), 32'(rsp_timeout), 32'(mon_exp.timeout));
        rsp_idx++;
      end
    end
  end

  initial begin
    #800000;
    miscompares++;
    $display("FAIL watchdog: still running at %0t, required completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  task automatic send_cmd(input logic [2:0] cfg, input logic [1:0] l2, input logic keep,
                          input bit push, input logic [15:0] ev, input logic et);
    int n;
    rsp_t e;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_sens_config = cfg;
    cmd_log2_samples = l2;
    cmd_keep_powered = keep;
    if (push) begin
      e.value = ev;
      e.timeout = et;
      exp_q.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_read(output int n, output bit en_ok);
    n = 0;
    en_ok = 1'b1;
    while (!sens_read && n < 2000) begin
      if (!(sens_enable && adc_enable)) en_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!(sens_enable && adc_enable && adc_read)) en_ok = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("rsp_arrived", 32'(rsp_valid), 32'd1);
  endtask

  function automatic logic [9:0] outs();
    return {cmd_ready, rsp_valid, rsp_timeout, sens_enable, adc_enable, sens_read, adc_read, sens_config};
  endfunction

  initial begin
    int n, r0;
    bit ok, stable;
    logic [15:0] v0;
    logic t0;
    logic [15:0] exp_avg;
    int exp_pulses;

    rst = 1'b1; abort = 1'b0; cmd_valid = 1'b0; cmd_sens_config = '0;
    cmd_log2_samples = '0; cmd_keep_powered = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(outs()), 32'h200);
    check("reset_rsp_value", 32'(rsp_value), 32'd0);
    rst = 1'b0;

    // Single sample, full settle, power down at DONE.
    adc_delay = 20;
    adc_vals = '{16'h1234};
    send_cmd(3'b101, 2'd0, 1'b0, 1'b1, 16'h1234, 1'b0);
    check("t1_cfg_enables", 32'({sens_config, sens_enable, adc_enable}), 32'({3'b101, 2'b11}));
    wait_read(n, ok);
    check("t1_settle_cycles", 32'(n), 32'(SETTLE));
    check("t1_enabled_in_settle", 32'(ok), 32'd1);
    wait_rsp(n);
    check("t1_enables_done", 32'({sens_enable, adc_enable}), 32'd0);
    @(negedge clk);

    // Four-sample average (one sample when averaging is not built in).
`ifdef ADC_SEQ_AVERAGING_EN
    exp_avg = 16'd250;
    exp_pulses = 4;
`else
    exp_avg = 16'd100;
    exp_pulses = 1;
`endif
    adc_delay = 3;
    adc_vals = '{16'd100, 16'd200, 16'd300, 16'd401};
    r0 = read_rises;
    send_cmd(3'b011, 2'd2, 1'b0, 1'b1, exp_avg, 1'b0);
    wait_rsp(n);
    check("t2_read_pulses", 32'(read_rises - r0), 32'(exp_pulses));
    @(negedge clk);
    adc_vals.delete();

    // Timeout: never completes; keep ignored, powers down.
    adc_hang = 1'b1;
    send_cmd(3'b001, 2'd0, 1'b1, 1'b1, 16'h0000, 1'b1);
    wait_read(n, ok);
    check("t3_settle_cycles", 32'(n), 32'(SETTLE));
    wait_rsp(n);
    check("t3_timeout_cycles", 32'(n), 32'(TIMEOUT));
    check("t3_enables_done", 32'({sens_enable, adc_enable}), 32'd0);
    check("t3_value_flag", 32'({rsp_value, rsp_timeout}), 32'({16'h0000, 1'b1}));
    @(negedge clk);
    adc_hang = 1'b0;
    adc_delay = 5;
    adc_vals = '{16'h0777};
    send_cmd(3'b001, 2'd0, 1'b0, 1'b1, 16'h0777, 1'b0);
    wait_read(n, ok);
    check("t3_resettle_cycles", 32'(n), 32'(SETTLE));
    wait_rsp(n);
    @(negedge clk);

    // Keep powered: same config skips settle, new config settles.
    adc_delay = 2;
    adc_vals = '{16'hABCD, 16'h4321, 16'h0F0F};
    send_cmd(3'b010, 2'd0, 1'b1, 1'b1, 16'hABCD, 1'b0);
    wait_read(n, ok);
    check("t4_first_settle", 32'(n), 32'(SETTLE));
    wait_rsp(n);
    @(negedge clk);
    check("t4_kept_powered", 32'({cmd_ready, sens_enable, adc_enable}), 32'h7);
    send_cmd(3'b010, 2'd0, 1'b1, 1'b1, 16'h4321, 1'b0);
    wait_read(n, ok);
    check("t4_skip_settle", 32'(n), 32'd0);
    wait_rsp(n);
    @(negedge clk);
    send_cmd(3'b110, 2'd0, 1'b0, 1'b1, 16'h0F0F, 1'b0);
    wait_read(n, ok);
    check("t4_new_cfg_settle", 32'(n), 32'(SETTLE));
    check("t4_new_cfg", 32'(sens_config), 32'd6);
    wait_rsp(n);
    @(negedge clk);

    // Abort mid-settle.
    send_cmd(3'b100, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0);
    repeat (50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_abort_settle", 32'(outs()), 32'h200);
    check("t5_abort_value", 32'(rsp_value), 32'd0);

    // Back-pressure: response held stable, commands refused.
    rsp_ready = 1'b0;
    adc_delay = 4;
    adc_vals = '{16'h5A5A};
    send_cmd(3'b111, 2'd0, 1'b0, 1'b1, 16'h5A5A, 1'b0);
    wait_rsp(n);
    v0 = rsp_value;
    t0 = rsp_timeout;
    stable = 1'b1;
    cmd_valid = 1'b1;
    cmd_sens_config = 3'b000;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_value !== v0 || rsp_timeout !== t0 || !rsp_valid || cmd_ready) stable = 1'b0;
    end
    cmd_valid = 1'b0;
    check("t6_held_value", 32'(v0), 32'h5A5A);
    check("t6_stable", 32'(stable), 32'd1);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_after_accept", 32'({cmd_ready, rsp_valid}), 32'b10);

    // Abort while a response is held: dropped without handshake.
    rsp_ready = 1'b0;
    adc_delay = 4;
    adc_vals = '{16'h1111};
    send_cmd(3'b011, 2'd0, 1'b1, 1'b0, 16'h0000, 1'b0);
    wait_rsp(n);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t7_abort_done", 32'(outs()), 32'h200);
    check("t7_abort_value", 32'(rsp_value), 32'd0);
    rsp_ready = 1'b1;
    adc_vals = '{16'h2222};
    send_cmd(3'b011, 2'd0, 1'b0, 1'b1, 16'h2222, 1'b0);
    wait_read(n, ok);
    check("t7_powered_cleared", 32'(n), 32'(SETTLE));
    wait_rsp(n);
    repeat (5) @(negedge clk);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
